// File: rtl/gcd_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : gcd_dispatch
// Purpose  : Front end for the 32-bit GCD core. Operand pairs arriving on a
//            valid/ready stream are buffered in a small FIFO. They are issued
//            to the core one at a time. Each result is returned with its
//            caller tag on a valid/ready output stream. The core has no
//            backpressure and a sticky done, so all flow control lives here.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk_i, rst_ni         - clock (posedge), async active-low reset
//            in_valid_i/in_ready_o - operand stream handshake
//            in_a_i, in_b_i        - operands A and B
//            in_tag_i              - caller tag
//            core_start_o          - one-cycle start pulse to the core
//            core_a_o, core_b_o    - operands held stable through WAIT
//            core_done_i           - sticky core done
//            core_result_i         - core result
//            out_valid_o/out_ready_i - result stream handshake
//            out_result_o          - GCD result
//            out_tag_o             - tag of the pair that produced the result
//            out_err_o             - watchdog timeout flag (0 without feature)
//            busy_o                - FSM active or FIFO non-empty
//            fifo_count_o          - FIFO occupancy
// Config   : define GCD_DISPATCH_TIMEOUT_EN to enable the WAIT watchdog
//            (TIMEOUT_CYCLES) and the DRAIN state that follows a timeout.
// ============================================================================
module gcd_dispatch #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [WIDTH-1:0]       in_a_i,
    input  logic [WIDTH-1:0]       in_b_i,
    input  logic [TAG_W-1:0]       in_tag_i,
    output logic                   core_start_o,
    output logic [WIDTH-1:0]       core_a_o,
    output logic [WIDTH-1:0]       core_b_o,
    input  logic                   core_done_i,
    input  logic [WIDTH-1:0]       core_result_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WIDTH-1:0]       out_result_o,
    output logic [TAG_W-1:0]       out_tag_o,
    output logic                   out_err_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] fifo_count_o
);

    localparam int             PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("gcd_dispatch: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3
`ifdef GCD_DISPATCH_TIMEOUT_EN
        , ST_DRAIN = 3'd4
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fifo_a_q   [DEPTH];
    logic [WIDTH-1:0] fifo_b_q   [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    assign in_ready_o = (count_q != FULL_COUNT);
    assign push       = in_valid_i && in_ready_o;

    // Storage carries no reset; the pointers and the count define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_a_q[wr_ptr_q]   <= in_a_i;
            fifo_b_q[wr_ptr_q]   <= in_b_i;
            fifo_tag_q[wr_ptr_q] <= in_tag_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [TAG_W-1:0] op_tag_q, op_tag_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;

`ifdef GCD_DISPATCH_TIMEOUT_EN
    localparam int             CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic             err_q, err_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_tag_d = op_tag_q;
        res_d    = res_q;
        tag_d    = tag_q;
        pop      = 1'b0;
`ifdef GCD_DISPATCH_TIMEOUT_EN
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    op_a_d   = fifo_a_q[rd_ptr_q];
                    op_b_d   = fifo_b_q[rd_ptr_q];
                    op_tag_d = fifo_tag_q[rd_ptr_q];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The core clears its sticky done on the edge that samples
                // start, so done is trustworthy from the first WAIT cycle.
                state_d = ST_WAIT;
`ifdef GCD_DISPATCH_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (core_done_i) begin
                    res_d   = core_result_i;
                    tag_d   = op_tag_q;
                    state_d = ST_OUT;
`ifdef GCD_DISPATCH_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    res_d   = '0;
                    tag_d   = op_tag_q;
                    err_d   = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
`ifdef GCD_DISPATCH_TIMEOUT_EN
                    // A timed-out job is still running in the core; wait
                    // for it before issuing anything new.
                    state_d = err_q ? ST_DRAIN : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef GCD_DISPATCH_TIMEOUT_EN
            ST_DRAIN: begin
                if (core_done_i) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_tag_q <= '0;
            res_q    <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_tag_q <= op_tag_d;
            res_q    <= res_d;
            tag_q    <= tag_d;
        end
    end

`ifdef GCD_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
    assign out_err_o = err_q;
`else
    assign out_err_o = 1'b0;
`endif

    assign core_start_o = (state_q == ST_ISSUE);
    assign core_a_o     = op_a_q;
    assign core_b_o     = op_b_q;
    assign out_valid_o  = (state_q == ST_OUT);
    assign out_result_o = res_q;
    assign out_tag_o    = tag_q;
    assign busy_o       = (state_q != ST_IDLE) || (count_q != '0);
    assign fifo_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_dispatch
// Purpose  : Directed self-checking bench for gcd_dispatch with a behavioural
//            GCD core stub (fixed latency, sticky done, optional hang).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_dispatch;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 4;
    localparam int TAG_W    = 4;
    localparam int CORE_LAT = 4;
`ifdef GCD_DISPATCH_TIMEOUT_EN
    localparam int TO_CYCLES = 8;
`else
    localparam int TO_CYCLES = 1024;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid, in_ready;
    logic [WIDTH-1:0]       in_a, in_b;
    logic [TAG_W-1:0]       in_tag;
    logic                   core_start;
    logic [WIDTH-1:0]       core_a, core_b;
    logic                   core_done;
    logic [WIDTH-1:0]       core_result;
    logic                   out_valid, out_ready;
    logic [WIDTH-1:0]       out_result;
    logic [TAG_W-1:0]       out_tag;
    logic                   out_err;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   hang;

    always #5 clk = ~clk;

    gcd_dispatch #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
        .core_start_o(core_start), .core_a_o(core_a), .core_b_o(core_b),
        .core_done_i(core_done), .core_result_i(core_result),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_tag_o(out_tag), .out_err_o(out_err),
        .busy_o(busy), .fifo_count_o(fifo_count)
    );

    // ---------------- core stub ----------------
    function automatic logic [WIDTH-1:0] gcd_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    int   core_cnt;
    logic core_pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done   <= 1'b0;
            core_result <= '0;
            core_cnt    <= 0;
            core_pend   <= 1'b0;
        end else if (core_start) begin
            core_done   <= 1'b0;
            core_pend   <= 1'b1;
            core_cnt    <= CORE_LAT - 1;
            core_result <= gcd_f(core_a, core_b);
        end else if (core_pend) begin
            if (core_cnt != 0) core_cnt <= core_cnt - 1;
            else if (!hang) begin
                core_done <= 1'b1;
                core_pend <= 1'b0;
            end
        end
    end

    // ---------------- monitors ----------------
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] tag;
        logic             err;
    } res_t;

    res_t got_q[$];
    res_t exp_q[$];
    int   n_starts = 0;

    always @(negedge clk) begin
        if (core_start) n_starts++;
        if (out_valid && out_ready) got_q.push_back({out_result, out_tag, out_err});
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("push_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check_eq({name, "_valid"}, out_valid, 1);
    endtask

    task automatic expect_results(input string name);
        int   guard;
        int   n;
        res_t g, e;
        guard = 0;
        n     = exp_q.size();
        while (got_q.size() < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_eq({name, "_count"}, got_q.size(), n);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_eq({name, "_result"}, g.res, e.res);
            check_eq({name, "_tag"}, g.tag, e.tag);
            check_eq({name, "_err"}, g.err, e.err);
        end
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] fa [5] = '{12, 100, 17, 81, 1071};
    logic [WIDTH-1:0] fb [5] = '{8, 75, 5, 27, 462};
    logic [WIDTH-1:0] fr [5] = '{4, 25, 1, 27, 21};
    logic [WIDTH-1:0] ba [4] = '{0, 0, 7, 270};
    logic [WIDTH-1:0] bb [4] = '{7, 0, 0, 192};
    logic [WIDTH-1:0] br [4] = '{7, 0, 7, 6};

    initial begin
        int lat;
        int s0;
        int bad;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        hang      = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        check_eq("rst_in_ready",   in_ready,   1);
        check_eq("rst_out_valid",  out_valid,  0);
        check_eq("rst_busy",       busy,       0);
        check_eq("rst_fifo_count", fifo_count, 0);
        check_eq("rst_core_start", core_start, 0);
        check_eq("rst_out_result", out_result, 0);
        check_eq("rst_out_err",    out_err,    0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single pair, latency 3 + core cycles
        out_ready = 1'b1;
        s0 = n_starts;
        push(48, 18, 3);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 100);
        check_eq("single_latency", lat, 3 + CORE_LAT);
        check_eq("single_out_result", out_result, 6);
        check_eq("single_out_tag", out_tag, 3);
        exp_q.push_back({32'd6, 4'd3, 1'b0});
        expect_results("single");
        check_eq("single_starts", n_starts - s0, 1);

        // fill FIFO with back-to-back pushes
        s0 = n_starts;
        for (int i = 0; i < 5; i++) begin
            push(fa[i], fb[i], TAG_W'(i));
            exp_q.push_back({fr[i], TAG_W'(i), 1'b0});
        end
        check_eq("fill_fifo_count", fifo_count, DEPTH);
        check_eq("fill_in_ready", in_ready, 0);
        expect_results("fill");
        check_eq("fill_starts", n_starts - s0, 5);

        // backpressure plus zero operands
        out_ready = 1'b0;
        s0 = n_starts;
        push(36, 24, 5);
        exp_q.push_back({32'd12, 4'd5, 1'b0});
        wait_out_valid("bp");
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            push(ba[i], bb[i], TAG_W'(6 + i));
            exp_q.push_back({br[i], TAG_W'(6 + i), 1'b0});
        end
        check_eq("bp_fifo_count", fifo_count, DEPTH);
        check_eq("bp_in_ready", in_ready, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || out_result !== 12 || out_tag !== 5) bad++;
        end
        check_eq("bp_stable_cycles_bad", bad, 0);
        check_eq("bp_starts_held", n_starts - s0, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_results("bp");
        check_eq("bp_starts", n_starts - s0, 5);

        // reset in the middle of WAIT
        push(48, 18, 1);
        push(5, 5, 2);
        push(9, 3, 3);
        @(posedge clk);
        #1;
        check_eq("midwait_core_a", core_a, 48);
        check_eq("midwait_core_b", core_b, 18);
        check_eq("midwait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_fifo_count", fifo_count, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_core_a", core_a, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        @(posedge clk);
        #1;
        push(1071, 462, 2);
        exp_q.push_back({32'd21, 4'd2, 1'b0});
        expect_results("after_rst");

`ifdef GCD_DISPATCH_TIMEOUT_EN
        // watchdog: the stub never finishes until released
        out_ready = 1'b0;
        hang      = 1'b1;
        s0        = n_starts;
        push(48, 18, 4);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 100);
        check_eq("to_latency", lat, 2 + TO_CYCLES);
        check_eq("to_out_err", out_err, 1);
        check_eq("to_out_result", out_result, 0);
        exp_q.push_back({32'd0, 4'd4, 1'b1});
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(270, 192, 9);
        exp_q.push_back({32'd6, 4'd9, 1'b0});
        repeat (15) @(posedge clk);
        #1;
        check_eq("to_drain_no_start", n_starts - s0, 1);
        hang = 1'b0;
        expect_results("to");
        check_eq("to_starts", n_starts - s0, 2);
        check_eq("to_err_cleared", out_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
